// File: rtl/tt_um_plc_prg.sv
// -----------------------------------------------------------------------------
// tt_um_plc_prg
// Small PLC-style output controller with two operating modes:
//   MAN  : Control follows start directly (no clock involved).
//   AUTO : Control is start gated by a TON on-delay timer. The output only
//          asserts once start has been seen high on TON_PRESET consecutive
//          rising clock edges.
// MAN wins when both mode inputs are set. When neither is set, Control is 0.
//
// Ports
//   clk      : sole clock, rising edge active
//   rst_n    : reset, asynchronous, ACTIVE-HIGH despite the name
//   ena      : design enable, ignored
//   ui_in    : [0]=start, [1]=AUTO, [2]=MAN, [7:3] unused
//   uo_out   : [0]=Control, [1]=timer_done, [2]=auto_active,
//              [3]=man_active, [4]=timer_running, [7:5]=0
//   uio_in   : unused
//   uio_out  : constant 0
//   uio_oe   : constant 0 (all bidirectional pins are inputs)
//
// Inputs are consumed unsynchronized; synchronizing them is left to the
// surrounding system.
// -----------------------------------------------------------------------------
module tt_um_plc_prg #(
  parameter logic [31:0] TON_PRESET = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic        start_s;
  logic        auto_in_s;
  logic        man_in_s;
  logic        man_active_s;
  logic        auto_active_s;
  logic        timer_done_s;
  logic        timer_running_s;
  logic        control_s;
  logic [31:0] cnt_r;

  // Inputs that play no part in the logic are collected here so they are
  // visibly accounted for.
  logic        unused_s;
  assign unused_s = &{1'b0, ena, uio_in, ui_in[7:3]};

  assign start_s   = ui_in[0];
  assign auto_in_s = ui_in[1];
  assign man_in_s  = ui_in[2];

  // Mode decode: MAN takes priority over AUTO.
  always_comb begin
    man_active_s  = man_in_s;
    auto_active_s = auto_in_s & ~man_in_s;
  end

  // On-delay counter: counts edges with AUTO+start, saturating at the preset;
  // any edge without that condition (mode change, start drop) restarts it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_r <= 32'd0;
    end else if (auto_active_s && start_s) begin
      if (cnt_r < TON_PRESET) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= TON_PRESET;
      end
    end else begin
      cnt_r <= 32'd0;
    end
  end

  // Timer status and Control selection. Control is deliberately combinational
  // so MAN mode and an AUTO start drop act with zero-cycle latency.
  always_comb begin
    timer_done_s    = (cnt_r == TON_PRESET);
    timer_running_s = auto_active_s & start_s & ~timer_done_s;
    control_s       = 1'b0;
    if (man_active_s) begin
      control_s = start_s;
    end else if (auto_active_s) begin
      control_s = start_s & timer_done_s;
    end else begin
      control_s = 1'b0;
    end
  end

  // Output assembly; reset forces every status bit low, including MAN Control.
  always_comb begin
    uo_out = 8'h00;
    if (rst_n) begin
      uo_out = 8'h00;
    end else begin
      uo_out = {3'b000, timer_running_s, man_active_s, auto_active_s,
                timer_done_s, control_s};
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_plc_prg.sv
// -----------------------------------------------------------------------------
// tb_tt_um_plc_prg
// Directed scenarios plus randomized mode/start/reset sequences, checked
// against a reference model that remembers which recent clock edges saw
// AUTO-mode start high. The timer is "done" when the last PRESET edges all
// qualified.
// -----------------------------------------------------------------------------
module tb_tt_um_plc_prg;

  localparam int PRESET = 20;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;

  // Qualifying-edge history since the last reset, newest at the back.
  bit hist[$];

  tt_um_plc_prg #(.TON_PRESET(32'd20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic bit model_done();
    int ones;
    ones = 0;
    foreach (hist[i]) ones += int'(hist[i]);
    return (hist.size() == PRESET) && (ones == PRESET);
  endfunction

  function automatic logic [7:0] model_uo();
    logic st, aut, man, done, ctl;
    if (rst_n) return 8'h00;
    st   = ui_in[0];
    man  = ui_in[2];
    aut  = ui_in[1] & ~ui_in[2];
    done = model_done();
    if (man)      ctl = st;
    else if (aut) ctl = st & done;
    else          ctl = 1'b0;
    return {3'b000, aut & st & ~done, man, aut, done, ctl};
  endfunction

  task automatic check(input string tag);
    logic [7:0] exp;
    exp = model_uo();
    n_cmp++;
    assert (uo_out === exp) else begin
      n_err++;
      $error("FAIL %s uo_out observed=%h expected=%h", tag, uo_out, exp);
    end
    n_cmp++;
    assert ((uio_out === 8'h00) && (uio_oe === 8'h00)) else begin
      n_err++;
      $error("FAIL %s uio observed out=%h oe=%h expected 00/00", tag, uio_out, uio_oe);
    end
  endtask

  task automatic check_ctl(input string tag, input logic exp);
    n_cmp++;
    assert (uo_out[0] === exp) else begin
      n_err++;
      $error("FAIL %s control observed=%b expected=%b", tag, uo_out[0], exp);
    end
  endtask

  // Advance one rising edge, update the model with the inputs seen there,
  // and leave time 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) hist.delete();
    else begin
      hist.push_back(ui_in[1] & ~ui_in[2] & ui_in[0]);
      if (hist.size() > PRESET) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic set_in(input logic man, input logic aut, input logic st);
    ui_in = {5'($urandom_range(0, 31)), man, aut, st};
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b1;
    hist.delete();
    #1;
    check("rst_assert");
    n_cmp++;
    assert (uo_out === 8'h00) else begin
      n_err++;
      $error("FAIL rst_zero uo_out observed=%h expected=00", uo_out);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_release");
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #1;
    check("reset_state");
    // MAN + start during reset must still read 0.
    set_in(1'b1, 1'b0, 1'b1);
    check("reset_man");
    tick();
    tick();
    rst_n = 1'b0;
    set_in(1'b0, 1'b1, 1'b1);
    check("auto_start");

    // AUTO held: Control exactly from the 20th edge on.
    for (int i = 1; i <= 25; i++) begin
      tick();
      check("auto_hold");
      check_ctl("auto_hold_ctl", (i >= PRESET));
    end

    // Short pulse then retrigger.
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_ctl("short_pulse_ctl", 1'b0);
    end
    set_in(1'b0, 1'b1, 1'b0);
    check("start_drop");
    tick();
    set_in(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 22; i++) begin
      tick();
      check("retrigger");
      check_ctl("retrigger_ctl", (i >= PRESET));
    end

    // MAN follows start with no edge.
    set_in(1'b1, 1'b0, 1'b0);
    check_ctl("man_low", 1'b0);
    set_in(1'b1, 1'b0, 1'b1);
    check_ctl("man_rise", 1'b1);
    check("man_rise");
    set_in(1'b1, 1'b0, 1'b0);
    check_ctl("man_fall", 1'b0);
    tick();
    check("man_after_edge");

    // Both modes: MAN wins.
    set_in(1'b1, 1'b1, 1'b1);
    check_ctl("both_ctl", 1'b1);
    n_cmp++;
    assert (uo_out[3:2] === 2'b10) else begin
      n_err++;
      $error("FAIL both_modes observed=%b expected=10", uo_out[3:2]);
    end
    repeat (3) begin tick(); check("both"); end

    // No mode selected.
    set_in(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("none");
      n_cmp++;
      assert (uo_out[4:0] === 5'b00000) else begin
        n_err++;
        $error("FAIL none_bits observed=%b expected=00000", uo_out[4:0]);
      end
    end

    // Reset while Control is high in AUTO, then timing restarts from 0.
    set_in(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < PRESET; i++) tick();
    check_ctl("pre_reset_ctl", 1'b1);
    pulse_reset();
    for (int i = 1; i <= 21; i++) begin
      tick();
      check_ctl("post_reset_ctl", (i >= PRESET));
    end

    // Randomized segments with occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      logic man, aut, st;
      int len;
      man = 1'($urandom_range(0, 3) == 0);
      aut = 1'($urandom_range(0, 3) != 0);
      st  = 1'($urandom_range(0, 3) != 0);
      uio_in = 8'($urandom);
      set_in(man, aut, st);
      check("rnd_comb");
      if ($urandom_range(0, 9) == 0) pulse_reset();
      len = int'($urandom_range(1, 30));
      for (int k = 0; k < len; k++) begin
        tick();
        check("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_plc_prg.md
TT_UM_PLC_PRG -- requirements
Module: tt_um_plc_prg

Interface
REQ-001 Parameter TON_PRESET, default 50_000_000 (1 s at 50 MHz); on-delay timer preset in clock cycles, range 1..2^32-1; benches use 20.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-high: block is in reset while rst_n=1.
REQ-004 ena  input  1  design-enable; ignored by the logic.
REQ-005 ui_in  input  8  [0]=start, [1]=AUTO, [2]=MAN; [7:3] unused.
REQ-006 uo_out  output  8  [0]=Control, [1]=timer_done, [2]=auto_active, [3]=man_active, [4]=timer_running, [7:5]=0.
REQ-007 uio_in  input  8  unused.
REQ-008 uio_out  output  8  constant 0.
REQ-009 uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Function
REQ-010 Mode decode is combinational: man_active = MAN; auto_active = AUTO and not MAN; MAN has priority when both are set.
REQ-011 Neither mode selected: Control=0 whatever start is; timer held cleared.
REQ-012 MAN mode: Control = start combinationally, with zero-cycle latency on both rising and falling start edges.
REQ-013 AUTO mode implements a TON on-delay timer with a 32-bit counter cnt.
REQ-014 At each rising clk edge: if auto_active and start, then cnt increments when cnt < TON_PRESET and saturates at TON_PRESET; otherwise cnt clears to 0.
REQ-015 timer_done = (cnt == TON_PRESET); timer_running = auto_active and start and not timer_done.
REQ-016 AUTO Control = start and timer_done, so Control rises on the TON_PRESET-th consecutive rising edge with start=1.
REQ-017 AUTO start drop: Control falls combinationally in the same cycle; cnt clears on the next edge.
REQ-018 Start pulse shorter than TON_PRESET cycles: Control stays 0; a retrigger restarts the count from 0.
REQ-019 Mode change from AUTO to MAN or none clears cnt at the next edge; returning to AUTO restarts timing from 0.
REQ-020 Inputs are used unsynchronized; input synchronization is the system integrator's responsibility.

Reset
REQ-021 While rst_n=1: cnt=0 asynchronously, and all of uo_out is forced to 0, including Control in MAN mode.
REQ-022 After rst_n returns to 0, normal operation begins at the next rising edge with cnt=0.
REQ-023 Reset asserted mid-count or while Control=1: outputs drop immediately and timing restarts from 0 after release.

Verification (TON_PRESET=20, clk 20 ns)
REQ-024 Reset pulse, then AUTO=1, MAN=0, start=1 held -> Control=0 for 19 edges, Control=1 and uo_out[1]=1 from the 20th edge, held while start=1.
REQ-025 AUTO, start=1 for 10 cycles, then 0, then 1 again -> Control never asserts early; after the retrigger it asserts on the 20th edge.
REQ-026 MAN=1, AUTO=0; start 0->1->0 -> Control follows start within 1 ns, with no clock edge needed.
REQ-027 AUTO=1, MAN=1, start=1 for 50 ns -> Control=1 immediately, uo_out[3]=1, uo_out[2]=0.
REQ-028 AUTO=0, MAN=0, start=1 for 100 ns -> Control=0 and uo_out[4:1]=0.
REQ-029 Reset asserted while Control=1 in AUTO -> uo_out=0 immediately; uio_out=0 and uio_oe=0 throughout all scenarios.
